reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 114 +++++++++++
 tb/tb_reg_file_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-read / two-write register file with registered reads,
// write-collision flag and a sequential clear engine (one entry per cycle).
// Optional macro REGFILE_BYPASS_EN: write-first forwarding of same-edge write
// data to reads of the same address. Without it reads are read-first.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              clr_req,
    output logic              busy,
    output logic              wcol
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, stateNext;
    logic [ADDR_W-1:0]       clrPtr;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [1:0][ADDR_W-1:0]  rAddr;
    logic                    clearing, lastClr, colHit, wen0, wen1;

    // Entry 0 is hardwired to zero when ZERO_REG is set.
    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign clearing = (state == CLEAR);
    // DEPTH is a power of two, so the last entry is the all-ones pointer.
    assign lastClr  = (clrPtr == '1);
    assign colHit   = we0 && we1 && (waddr0 == waddr1);
    // Port 1 wins a collision, so port 0 simply drops out.
    assign wen1     = !clearing && we1 && !isZero(waddr1);
    assign wen0     = !clearing && we0 && !isZero(waddr0) && !colHit;
    assign busy     = clearing;
    assign rAddr    = {raddr1, raddr0};

    // State register; reset parks the block in CLEAR so storage gets zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLEAR;
        else        state <= stateNext;
    end

    // Next state: clr_req only matters in IDLE; CLEAR runs to the last entry.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (clr_req) stateNext = CLEAR;
            CLEAR:   if (lastClr) stateNext = IDLE;
            default: stateNext = CLEAR;
        endcase
    end

    // Clear pointer walks 0..DEPTH-1 while clearing and returns to 0 on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  clrPtr <= '0;
        else if (clearing && !lastClr) clrPtr <= clrPtr + 1'b1;
        else                         clrPtr <= '0;
    end

    // Collision flag: one-cycle pulse, suppressed while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcol <= 1'b0;
        else        wcol <= !clearing && colHit;
    end

    // Storage has no reset; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clrPtr] <= '0;
        end else begin
            if (wen0) mem[waddr0] <= wdata0;
            if (wen1) mem[waddr1] <= wdata1;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : gRd
        logic [DATA_W-1:0] fwd;
        logic [DATA_W-1:0] q;

        // Read source: array contents, optionally overridden by same-edge writes.
        always_comb begin
            fwd = mem[rAddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wen1 && (waddr1 == rAddr[p]))      fwd = wdata1;
            else if (wen0 && (waddr0 == rAddr[p])) fwd = wdata0;
`endif
        end

        // Registered read port; forced to zero while clearing or for entry 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                           q <= '0;
            else if (clearing || isZero(rAddr[p])) q <= '0;
            else                                  q <= fwd;
        end
    end

    assign rdata0 = gRd[0].q;
    assign rdata1 = gRd[1].q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected values tagged
// with the cycle they must appear in; a negedge monitor pops and compares.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  raddr0, raddr1, waddr0, waddr1;
    logic [31:0] rdata0, rdata1, wdata0, wdata1;
    logic        we0, we1, clr_req, busy, wcol;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .clr_req(clr_req), .busy(busy), .wcol(wcol)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sig;   // 0 rdata0, 1 rdata1, 2 busy, 3 wcol
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int d, input int s, input logic [31:0] v, input string n);
        exp_t e;
        e.due = d; e.sig = s; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin : mon
        exp_t        keep[$];
        logic [31:0] obs;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                case (sb[i].sig)
                    0:       obs = rdata0;
                    1:       obs = rdata1;
                    2:       obs = {31'b0, busy};
                    default: obs = {31'b0, wcol};
                endcase
                checks++;
                if (obs !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].name, cyc, obs, sb[i].val);
                end
            end else if (sb[i].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed due=%0d", sb[i].name, sb[i].due);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Release reset and expect busy for exactly 32 cycles; optionally
    // hammer the block with colliding writes and clr_req while it clears.
    task automatic releaseAndClear(input bit attack);
        int c0;
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 32; i++) begin
            push(c0 + i, 2, 1, "clr_busy");
            push(c0 + i + 1, 0, 0, "clr_rd0");
            push(c0 + i + 1, 1, 0, "clr_rd1");
            if (attack) begin
                we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
                we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h78;
                clr_req = (i % 5 == 0);
                push(c0 + i + 1, 3, 0, "clr_wcol");
            end
            step();
        end
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
        push(c0 + 32, 2, 0, "clr_done");
        step();
    endtask

    task automatic readAllZero();
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a);
            raddr1 = 5'(31 - a);
            push(cyc + 1, 0, 0, "zero_rd0");
            push(cyc + 1, 1, 0, "zero_rd1");
            step();
        end
    endtask

    initial begin : stim
        rst_n = 1'b0; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0;
        raddr0 = 5'd3; raddr1 = 5'd9;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) step();

        // reset state
        push(cyc, 2, 1, "rst_busy");
        push(cyc, 0, 0, "rst_rd0");
        push(cyc, 1, 0, "rst_rd1");
        push(cyc, 3, 0, "rst_wcol");
        releaseAndClear(1'b0);
        readAllZero();

        // basic write then dual read
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'd15;
        step();
        we0 = 1'b0; raddr0 = 5'd1; raddr1 = 5'd1;
        push(cyc + 1, 0, 15, "wr_rd0");
        push(cyc + 1, 1, 15, "wr_rd1");
        step();

        // collision: port 1 wins, wcol pulses once
        we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'd32;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'd7;
        push(cyc + 1, 3, 1, "wcol_hit");
        push(cyc + 2, 3, 0, "wcol_pulse");
        step();
        we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd2; raddr1 = 5'd1;
        push(cyc + 1, 0, 7, "col_winner");
        push(cyc + 1, 1, 15, "col_other");
        step();

        // independent dual write
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
        push(cyc + 1, 3, 0, "nocol_wcol");
        step();
        we0 = 1'b0; we1 = 1'b0; raddr0 = 5'd3; raddr1 = 5'd4;
        push(cyc + 1, 0, 32'h33, "dual_rd0");
        push(cyc + 1, 1, 32'h44, "dual_rd1");
        step();

        // address 0 is hardwired zero, even on a same-edge read
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD; raddr0 = 5'd0;
        push(cyc + 1, 0, 0, "z_same_edge");
        step();
        we0 = 1'b0; we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hBEEF; raddr1 = 5'd0;
        push(cyc + 1, 1, 0, "z_same_edge1");
        step();
        we1 = 1'b0;
        push(cyc + 1, 0, 0, "z_after");
        step();
        we0 = 1'b1; waddr0 = 5'd0; we1 = 1'b1; waddr1 = 5'd0;
        push(cyc + 1, 3, 1, "z_wcol");
        step();
        we0 = 1'b0; we1 = 1'b0;
        push(cyc + 1, 0, 0, "z_after_col");
        step();

        // same-edge read/write of entry 5
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'd3;
        step();
        wdata0 = 32'd9; raddr0 = 5'd5;
        push(cyc + 1, 0, BYP ? 32'd9 : 32'd3, "rw_same_edge");
        step();
        we0 = 1'b0;
        push(cyc + 1, 0, 9, "rw_after");
        step();

        // same-edge colliding write with reads of the target (entry 6 is 0)
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h60;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h61;
        raddr0 = 5'd6; raddr1 = 5'd6;
        push(cyc + 1, 0, BYP ? 32'h61 : 32'h0, "byp_pri0");
        push(cyc + 1, 1, BYP ? 32'h61 : 32'h0, "byp_pri1");
        step();
        we0 = 1'b0; we1 = 1'b0;
        push(cyc + 1, 0, 32'h61, "pri_after0");
        push(cyc + 1, 1, 32'h61, "pri_after1");
        step();

        // clr_req, writes during clear, reset at clear cycle 10
        clr_req = 1'b1; raddr0 = 5'd7; raddr1 = 5'd5;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(cyc, 2, 1, "clrreq_busy");
            we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h77;
            we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h78;
            clr_req = (i == 3);
            push(cyc + 1, 0, 0, "clrreq_rd0");
            push(cyc + 1, 3, 0, "clrreq_wcol");
            step();
        end
        rst_n = 1'b0;
        push(cyc, 2, 1, "midrst_busy");
        push(cyc, 0, 0, "midrst_rd0");
        push(cyc, 1, 0, "midrst_rd1");
        push(cyc, 3, 0, "midrst_wcol");
        step();
        step();
        releaseAndClear(1'b1);
        readAllZero();

        // normal operation resumes after the clear
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA5A5;
        step();
        we0 = 1'b0; raddr1 = 5'd7;
        push(cyc + 1, 1, 32'hA5A5, "post_clr_wr");
        step();
        repeat (2) step();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
